// File: rtl/fp_sched_pkg.sv
// fp_sched_pkg: shared constants and types for the shared fp16 adder scheduler
package fp_sched_pkg;
    localparam int ADDER_LATENCY_DEF = 6;
    localparam int FLAG_LATENCY_DEF  = 2;
    localparam int F_OVF  = 0;
    localparam int F_UNF  = 1;
    localparam int F_ZERO = 2;
    localparam int F_INF  = 3;
    localparam int F_NAN  = 4;
    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} sched_state_t;
endpackage

// File: rtl/fp_add_scheduler_if.sv
// fp_add_scheduler_if: requester, adder and response signals of the shared-adder scheduler
interface fp_add_scheduler_if #(parameter int NUM_REQ = 4);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_operand_a;
    logic [16*NUM_REQ-1:0] req_operand_b;
    logic [NUM_REQ-1:0]    req_op;
    logic [15:0]           adder_operand_a;
    logic [15:0]           adder_operand_b;
    logic                  adder_final_operation;
    logic [15:0]           adder_result;
    logic                  adder_overflow;
    logic                  adder_underflow;
    logic                  adder_zero;
    logic                  adder_infinity;
    logic                  adder_nan;
    logic                  resp_valid;
    logic [ID_W-1:0]       resp_id;
    logic [15:0]           resp_result;
    logic [4:0]            resp_flags;
    logic                  busy;
    modport slave (
        input  req_valid, req_operand_a, req_operand_b, req_op,
        input  adder_result, adder_overflow, adder_underflow, adder_zero, adder_infinity, adder_nan,
        output req_ready, adder_operand_a, adder_operand_b, adder_final_operation,
        output resp_valid, resp_id, resp_result, resp_flags, busy
    );
    modport master (
        output req_valid, req_operand_a, req_operand_b, req_op,
        output adder_result, adder_overflow, adder_underflow, adder_zero, adder_infinity, adder_nan,
        input  req_ready, adder_operand_a, adder_operand_b, adder_final_operation,
        input  resp_valid, resp_id, resp_result, resp_flags, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter; priority starts one past the last granted index
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       update,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0] ptr;
    logic [IW-1:0] c;
    always_comb begin
        idx = '0;
        any = 1'b0;
        c = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = IW'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[c]) begin
                any = 1'b1;
                idx = c;
            end
        end
    end
    assign grant = NUM_REQ'(any) << idx;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ptr <= IW'(NUM_REQ - 1);
        else if (update) ptr <= idx;
    end
endmodule

// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: round-robin front end sharing one pipelined fp16 adder; drains the
// pipeline before each add/sub mode change and returns results tagged with requester id
module fp_add_scheduler
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ADDER_LATENCY = ADDER_LATENCY_DEF,
    parameter int FLAG_LATENCY  = FLAG_LATENCY_DEF
) (
    input logic               clock,
    input logic               reset_n,
    fp_add_scheduler_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int FD = ADDER_LATENCY - FLAG_LATENCY;
    sched_state_t       state;
    logic               mode;
    logic [IW-1:0]      drain_id;
    logic [IW-1:0]      win_idx;
    logic [NUM_REQ-1:0] win_grant;
    logic               win_any;
    logic               xfer;
    logic               mismatch;
    logic               tail;
    logic [3:0]         count;
    logic               trk_v  [ADDER_LATENCY+1];
    logic [IW-1:0]      trk_id [ADDER_LATENCY+1];
    logic [2:0]         flg    [FD];
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .update  (xfer),
        .grant   (win_grant),
        .idx     (win_idx),
        .any     (win_any)
    );
    // a winner whose op differs from the current mode is held back until the pipeline empties
    assign xfer     = state == RUN && win_any && bus.req_op[win_idx] == mode;
    assign mismatch = state == RUN && win_any && bus.req_op[win_idx] != mode;
    assign bus.req_ready = xfer ? win_grant : '0;
    assign tail = trk_v[ADDER_LATENCY];
    assign bus.busy = count != 4'd0 || state == DRAIN;
    assign bus.adder_final_operation = mode;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            mode     <= 1'b0;
            drain_id <= '0;
            count    <= '0;
        end else begin
            count <= count + 4'(xfer) - 4'(tail);
            if (mismatch) begin
                state    <= DRAIN;
                drain_id <= win_idx;
            end else if (state == DRAIN && count == 4'd0) begin
                state <= RUN;
                if (bus.req_valid[drain_id]) mode <= bus.req_op[drain_id];
            end
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= ADDER_LATENCY; i++) begin
                trk_v[i]  <= 1'b0;
                trk_id[i] <= '0;
            end
            for (int i = 0; i < FD; i++) flg[i] <= '0;
            bus.adder_operand_a <= '0;
            bus.adder_operand_b <= '0;
            bus.resp_valid      <= 1'b0;
            bus.resp_id         <= '0;
            bus.resp_result     <= '0;
            bus.resp_flags      <= '0;
        end else begin
            trk_v[0]  <= xfer;
            trk_id[0] <= win_idx;
            for (int i = 1; i <= ADDER_LATENCY; i++) begin
                trk_v[i]  <= trk_v[i-1];
                trk_id[i] <= trk_id[i-1];
            end
            // zero/inf/nan arrive early; delay them to line up with the result
            flg[0] <= {bus.adder_nan, bus.adder_infinity, bus.adder_zero};
            for (int i = 1; i < FD; i++) flg[i] <= flg[i-1];
            bus.adder_operand_a <= xfer ? bus.req_operand_a[win_idx*16 +: 16] : '0;
            bus.adder_operand_b <= xfer ? bus.req_operand_b[win_idx*16 +: 16] : '0;
            bus.resp_valid      <= tail;
            bus.resp_id         <= tail ? trk_id[ADDER_LATENCY] : '0;
            bus.resp_result     <= tail ? bus.adder_result : '0;
            bus.resp_flags[F_OVF]  <= tail & bus.adder_overflow;
            bus.resp_flags[F_UNF]  <= tail & bus.adder_underflow;
            bus.resp_flags[F_ZERO] <= tail & flg[FD-1][0];
            bus.resp_flags[F_INF]  <= tail & flg[FD-1][1];
            bus.resp_flags[F_NAN]  <= tail & flg[FD-1][2];
        end
    end
endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb_fp_add_scheduler: directed vectors and corner sequences against a stub fp16 adder
module tb_fp_add_scheduler;
    localparam int NR   = 4;
    localparam int LAT  = 6;
    localparam int FLAT = 2;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    fp_add_scheduler_if #(.NUM_REQ(NR)) bus ();
    fp_add_scheduler #(.NUM_REQ(NR), .ADDER_LATENCY(LAT), .FLAG_LATENCY(FLAT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );
    initial forever #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // stub adder: exact for the operand pairs used here, {nan,inf,zero,unf,ovf,result}
    function automatic logic [20:0] stub(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [15:0] bb, r;
        logic fin;
        bb  = sub ? b ^ 16'h8000 : b;
        fin = a[14:10] != 5'h1F && bb[14:10] != 5'h1F;
        if (!fin)
            r = (a[14:10] == 5'h1F && a[9:0] != 0) || (bb[14:10] == 5'h1F && bb[9:0] != 0) ? 16'h7E00 :
                a[14:10] == 5'h1F ? a : bb;
        else if (a == (bb ^ 16'h8000)) r = 16'h0000;
        else if (a[14:0] == 0 && bb[14:0] == 0) r = 16'h0000;
        else if (a == bb) r = a[14:10] >= 5'h1E ? {a[15], 15'h7C00} : a + 16'h0400;
        else if (a == 16'h4000 && bb == 16'hBC00) r = 16'h3C00;
        else r = a ^ bb;
        return {r[14:10] == 5'h1F && r[9:0] != 0, r[14:0] == 15'h7C00, r[14:0] == 15'h0, 1'b0,
                fin && r[14:10] == 5'h1F, r};
    endfunction
    logic [20:0] s;
    logic [17:0] rp [LAT];
    logic [2:0]  fp [FLAT];
    assign s = stub(bus.adder_operand_a, bus.adder_operand_b, bus.adder_final_operation);
    always @(posedge clock) begin
        rp[0] <= s[17:0];
        for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
        fp[0] <= s[20:18];
        for (int i = 1; i < FLAT; i++) fp[i] <= fp[i-1];
    end
    assign bus.adder_result    = rp[LAT-1][15:0];
    assign bus.adder_overflow  = rp[LAT-1][16];
    assign bus.adder_underflow = rp[LAT-1][17];
    assign bus.adder_zero      = fp[FLAT-1][0];
    assign bus.adder_infinity  = fp[FLAT-1][1];
    assign bus.adder_nan       = fp[FLAT-1][2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask
    task automatic fail(input string name);
        n_chk++;
        n_bad++;
        $display("FAIL %s: bound expired, expected event never seen", name);
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic do_reset();
        reset_n = 1'b0;
        bus.req_valid = '0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask
    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b, input logic op);
        bus.req_operand_a[id*16 +: 16] = a;
        bus.req_operand_b[id*16 +: 16] = b;
        bus.req_op[id] = op;
    endtask
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic op, output int t);
        set_req(id, a, b, op);
        bus.req_valid[id] = 1'b1;
        t = -1;
        for (int k = 0; k < 40 && t < 0; k++) begin
            @(negedge clock);
            if (bus.req_ready[id]) t = cyc;
            tick();
        end
        bus.req_valid[id] = 1'b0;
        if (t < 0) fail("grant_timeout");
    endtask

    int gid [8], gcyc [8], ng;
    int rid [8], rcyc [8], nr;
    logic [15:0] rres [8];
    logic [4:0]  rflg [8];
    task automatic grants(input logic [NR-1:0] mask, input int n);
        ng = 0;
        bus.req_valid = mask;
        for (int k = 0; k < 40 && ng < n; k++) begin
            @(negedge clock);
            if ($countones(bus.req_ready) > 1) chk("ready_onehot", 32'($countones(bus.req_ready)), 1);
            for (int i = 0; i < NR; i++)
                if (bus.req_ready[i]) begin
                    gid[ng]  = i;
                    gcyc[ng] = cyc;
                end
            if (bus.req_ready != '0) ng++;
            tick();
        end
        bus.req_valid = '0;
        if (ng < n) fail("burst_grants");
    endtask
    task automatic resps(input int n);
        nr = 0;
        for (int k = 0; k < 40 && nr < n; k++) begin
            @(negedge clock);
            if (bus.resp_valid) begin
                rid[nr]  = int'(bus.resp_id);
                rcyc[nr] = cyc;
                rres[nr] = bus.resp_result;
                rflg[nr] = bus.resp_flags;
                nr++;
            end
            tick();
        end
        if (nr < n) fail("burst_resps");
    endtask

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] res;
        logic [4:0]  flags;
    } vec_t;
    vec_t vt [8];
    logic [15:0] rr_in  [4];
    logic [15:0] rr_res [5];
    int t0, rc, c, r0c, r1c, rdy, nresp;
    logic [15:0] r0res, r1res;
    logic fo8, fo9;

    initial begin
        vt[0] = '{2, 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 5'b00000};
        vt[1] = '{1, 16'h4000, 16'h3C00, 1'b1, 16'h3C00, 5'b00000};
        vt[2] = '{0, 16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 5'b01000};
        vt[3] = '{3, 16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 5'b10000};
        vt[4] = '{1, 16'h3C00, 16'h3C00, 1'b1, 16'h0000, 5'b00100};
        vt[5] = '{2, 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5'b01001};
        vt[6] = '{0, 16'hC000, 16'hC000, 1'b0, 16'hC400, 5'b00000};
        vt[7] = '{3, 16'h0000, 16'h0000, 1'b1, 16'h0000, 5'b00100};
        rr_in  = '{16'h3C00, 16'h4000, 16'h4400, 16'h4800};
        rr_res = '{16'h4000, 16'h4400, 16'h4800, 16'h4C00, 16'h4000};
        bus.req_valid = '0;
        bus.req_op = '0;
        bus.req_operand_a = '0;
        bus.req_operand_b = '0;

        // reset held for three cycles with everything idle
        repeat (3) @(negedge clock);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_operand_a", 32'(bus.adder_operand_a), 0);
        chk("rst_operand_b", 32'(bus.adder_operand_b), 0);
        chk("rst_final_op", 32'(bus.adder_final_operation), 0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_id", 32'(bus.resp_id), 0);
        chk("rst_resp_result", 32'(bus.resp_result), 0);
        chk("rst_resp_flags", 32'(bus.resp_flags), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_operand_a", 32'(bus.adder_operand_a), 0);
        chk("idle_operand_b", 32'(bus.adder_operand_b), 0);
        chk("idle_resp_valid", 32'(bus.resp_valid), 0);
        tick();

        for (int v = 0; v < 8; v++) begin
            issue(vt[v].id, vt[v].a, vt[v].b, vt[v].op, t0);
            rc = -1;
            for (int k = 0; k < 30 && rc < 0; k++) begin
                @(negedge clock);
                if (bus.resp_valid) begin
                    rc = cyc;
                    chk($sformatf("vec%0d_id", v), 32'(bus.resp_id), 32'(vt[v].id));
                    chk($sformatf("vec%0d_result", v), 32'(bus.resp_result), 32'(vt[v].res));
                    chk($sformatf("vec%0d_flags", v), 32'(bus.resp_flags), 32'(vt[v].flags));
                end
                tick();
            end
            if (rc < 0) fail($sformatf("vec%0d_resp", v));
            else chk($sformatf("vec%0d_latency", v), 32'(rc - t0), 8);
            repeat (2) tick();
            chk($sformatf("vec%0d_busy_after", v), 32'(bus.busy), 0);
        end

        // round-robin at full rate: 0,1,2,3,0 on consecutive cycles
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, rr_in[i], rr_in[i], 1'b0);
        grants(4'hF, 5);
        resps(5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_grant%0d_id", i), 32'(gid[i]), 32'(i % 4));
            chk($sformatf("rr_grant%0d_cycle", i), 32'(gcyc[i] - gcyc[0]), 32'(i));
            chk($sformatf("rr_resp%0d_id", i), 32'(rid[i]), 32'(i % 4));
            chk($sformatf("rr_resp%0d_result", i), 32'(rres[i]), 32'(rr_res[i]));
            chk($sformatf("rr_resp%0d_cycle", i), 32'(rcyc[i] - gcyc[0]), 32'(i + 8));
        end

        // add followed by sub from another requester: pipeline drains before the mode flips
        do_reset();
        set_req(1, 16'h4000, 16'h3C00, 1'b1);
        issue(0, 16'h3C00, 16'h3C00, 1'b0, t0);
        bus.req_valid[1] = 1'b1;
        r0c = -1; r1c = -1; rdy = -1; fo8 = 1'bx; fo9 = 1'bx; r0res = '0; r1res = '0;
        for (int k = 0; k < 30 && r1c < 0; k++) begin
            @(negedge clock);
            c = cyc - t0;
            if (bus.resp_valid && bus.resp_id == 0) begin r0c = c; r0res = bus.resp_result; end
            if (bus.resp_valid && bus.resp_id == 1) begin r1c = c; r1res = bus.resp_result; end
            if (bus.req_ready[1] && rdy < 0) rdy = c;
            if (c == 8) fo8 = bus.adder_final_operation;
            if (c == 9) fo9 = bus.adder_final_operation;
            tick();
            if (rdy >= 0) bus.req_valid[1] = 1'b0;
        end
        bus.req_valid = '0;
        chk("sw_resp0_cycle", 32'(r0c), 8);
        chk("sw_resp0_result", 32'(r0res), 32'h4000);
        chk("sw_ready1_cycle", 32'(rdy), 9);
        chk("sw_final_op_c8", 32'(fo8), 0);
        chk("sw_final_op_c9", 32'(fo9), 1);
        chk("sw_resp1_cycle", 32'(r1c), 17);
        chk("sw_resp1_result", 32'(r1res), 32'h3C00);

        // back-to-back inf, nan, normal: each flag stays with its own response
        do_reset();
        set_req(0, 16'h7C00, 16'h3C00, 1'b0);
        set_req(1, 16'h7E00, 16'h3C00, 1'b0);
        set_req(2, 16'h3C00, 16'h3C00, 1'b0);
        grants(4'b0111, 3);
        resps(3);
        chk("flg_inf_result", 32'(rres[0]), 32'h7C00);
        chk("flg_inf_flags", 32'(rflg[0]), 32'b01000);
        chk("flg_nan_result", 32'(rres[1]), 32'h7E00);
        chk("flg_nan_flags", 32'(rflg[1]), 32'b10000);
        chk("flg_norm_result", 32'(rres[2]), 32'h4000);
        chk("flg_norm_flags", 32'(rflg[2]), 32'b00000);

        // reset while three operations are in flight
        do_reset();
        grants(4'b0111, 3);
        tick();
        @(negedge clock);
        chk("mid_busy_before", 32'(bus.busy), 1);
        tick();
        reset_n = 1'b0;
        @(negedge clock);
        chk("mid_busy_in_reset", 32'(bus.busy), 0);
        tick();
        reset_n = 1'b1;
        nresp = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            if (bus.resp_valid) nresp++;
            tick();
        end
        chk("mid_no_resp", 32'(nresp), 0);
        chk("mid_busy_after", 32'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
